// File: rtl/serial_adder_8_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and the
// bit-counter width helper.
package serial_adder_8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice for WIDTH >= 2.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_8_fa_str.sv
// Structural 1-bit full adder built from gate primitives; the only
// arithmetic element of the serial adder datapath.
module FA_str (
    output wire c_out,
    output wire sum,
    input  wire a,
    input  wire b,
    input  wire c_in
);

    wire ab_xor;
    wire ab_and;
    wire cx_and;

    xor g_x1 (ab_xor, a, b);
    xor g_x2 (sum, ab_xor, c_in);
    and g_a1 (ab_and, a, b);
    and g_a2 (cx_and, ab_xor, c_in);
    or  g_o1 (c_out, ab_and, cx_and);

endmodule

// File: rtl/serial_adder_8.sv
// Bit-serial adder: one full adder processes one operand bit per clock,
// LSB first, producing sum and carry-out after WIDTH shift cycles.
module serial_adder_8
    import serial_adder_8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    FA_str u_fa (
        .c_out (fa_cout),
        .sum   (fa_sum),
        .a     (a_reg[0]),
        .b     (b_reg[0]),
        .c_in  (carry)
    );

    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // busy/done depend only on the state register, never on inputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // c_out has its own flop so the carry flop can be reloaded by the next
    // start without disturbing the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    c_out <= fa_cout;
                    carry <= fa_cout;
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_8.sv
// Directed self-checking bench for serial_adder_8 (WIDTH=8).
module tb_serial_adder_8;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] s5_a   [3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0] s5_b   [3] = '{8'h02, 8'h80, 8'hFF};
    logic       s5_c   [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] s5_sum [3] = '{8'h03, 8'h00, 8'hFF};
    logic       s5_co  [3] = '{1'b0, 1'b1, 1'b1};

    serial_adder_8 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called right after a falling edge with the DUT idle; returns one
    // falling edge after the done cycle.
    task automatic applyStimulus(input string tag, input logic [7:0] op_a,
                                 input logic [7:0] op_b, input logic op_c,
                                 input logic [7:0] exp_sum, input logic exp_c,
                                 input bit glitch);
        int         n;
        int         busy_cycles;
        int         extra_done;
        bit         seen;
        logic [8:0] model;
        model = {1'b0, op_a} + {1'b0, op_b} + {8'd0, op_c};
        a     = op_a;
        b     = op_b;
        c_in  = op_c;
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        n           = 1;
        busy_cycles = 0;
        seen        = 0;
        while (!seen && n <= WIDTH + 4) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_cycles++;
                if (glitch && n == 3) begin
                    a     = 8'h00;
                    b     = 8'h00;
                    start = 1'b1;
                end
                if (glitch && n == 4) start = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, n, WIDTH + 1);
        checkOutput({tag, "_busy_cycles"}, busy_cycles, WIDTH);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        checkOutput({tag, "_c_out"}, 32'(c_out), 32'(exp_c));
        checkOutput({tag, "_model"}, 32'({c_out, sum}), 32'(model));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        if (glitch) begin
            extra_done = 0;
            for (int i = 0; i < 12; i++) begin
                if (done || busy) extra_done++;
                @(negedge clk);
            end
            checkOutput({tag, "_no_queued_start"}, extra_done, 0);
            checkOutput({tag, "_sum_held"}, 32'(sum), 32'(exp_sum));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int idx;
        int last_done;
        int stray;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_c_out", 32'(c_out), 32'd0);

        start = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_over_start", 32'(busy), 32'd0);
        start = 1'b0;
        rst   = 1'b0;

        $display("[TB] scenario 1: 00+00+1");
        applyStimulus("s1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0);
        $display("[TB] scenario 2: FF+01+0");
        applyStimulus("s2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        $display("[TB] scenario 3: A5+5A+1 with mid-shift changes");
        applyStimulus("s3", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1);

        $display("[TB] scenario 4: reset mid-shift");
        a     = 8'h7F;
        b     = 8'h7F;
        c_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("s4_busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("s4_abort_busy", 32'(busy), 32'd0);
        checkOutput("s4_abort_done", 32'(done), 32'd0);
        checkOutput("s4_abort_sum", 32'(sum), 32'd0);
        checkOutput("s4_abort_c_out", 32'(c_out), 32'd0);
        rst   = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) stray++;
            @(negedge clk);
        end
        checkOutput("s4_no_done_after_abort", stray, 0);
        applyStimulus("s4b", 8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 0);

        $display("[TB] scenario 5: start held high");
        idx       = 0;
        last_done = -1;
        n         = 0;
        a         = s5_a[0];
        b         = s5_b[0];
        c_in      = s5_c[0];
        start     = 1'b1;
        while (idx < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (done) begin
                checkOutput($sformatf("s5_sum_%0d", idx), 32'(sum), 32'(s5_sum[idx]));
                checkOutput($sformatf("s5_c_out_%0d", idx), 32'(c_out), 32'(s5_co[idx]));
                if (idx > 0) begin
                    checkOutput($sformatf("s5_spacing_%0d", idx), n - last_done, WIDTH + 2);
                end
                last_done = n;
                idx++;
                if (idx < 3) begin
                    a    = s5_a[idx];
                    b    = s5_b[idx];
                    c_in = s5_c[idx];
                end
            end
        end
        start = 1'b0;
        checkOutput("s5_result_count", idx, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
